// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle ripple adder/subtractor.
// Processes CHUNK bits of a WIDTH-bit add or subtract per clock. The carry
// between chunks is held in a register, so the longest combinational carry
// path is only CHUNK bits long.
//
// Handshake (start/busy/done):
//   - start is sampled only while the FSM is idle (busy=0). The same edge
//     latches a, b, sub and cin. Any later change to those inputs has no effect.
//   - busy is high from the cycle after acceptance through the done cycle.
//     start seen while busy=1 is dropped, not queued.
//   - done is a one-cycle pulse. sum/cout/ovf are valid in that cycle and hold
//     in idle until the next accepted start. cout/ovf clear at acceptance.
//     sum is rewritten chunk by chunk during the run.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       state_dbg
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             c;
    logic             sub_q;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             carry_msb;

    // Add the current chunk. The carry into the chunk MSB (bit WIDTH-1 on the
    // last chunk) is recovered as a ^ b ^ s at that bit.
    always_comb begin
        a_chunk   = op_a[int'(idx)*CHUNK +: CHUNK];
        b_chunk   = op_b[int'(idx)*CHUNK +: CHUNK];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c};
        carry_msb = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
    end

    // Control FSM plus the operand, carry and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_a   <= '0;
            op_b   <= '0;
            c      <= 1'b0;
            sub_q  <= 1'b0;
            idx    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + ~borrow_in.
                        op_a   <= a;
                        op_b   <= sub ? ~b : b;
                        c      <= cin ^ sub;
                        sub_q  <= sub;
                        idx    <= '0;
                        cout_q <= 1'b0;
                        ovf_q  <= 1'b0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_q[int'(idx)*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    c <= chunk_sum[CHUNK];
                    if (idx == LAST_IDX) begin
                        // Borrow is the inverted raw carry. Overflow compares
                        // the carries into and out of the sign bit.
                        cout_q <= chunk_sum[CHUNK] ^ sub_q;
                        ovf_q  <= carry_msb ^ chunk_sum[CHUNK];
                        state  <= ST_DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Drive the outputs from the state and result registers.
    always_comb begin
        busy      = (state == ST_RUN) || (state == ST_DONE);
        done      = (state == ST_DONE);
        sum       = sum_q;
        cout      = cout_q;
        ovf       = ovf_q;
        state_dbg = state;
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: directed bench for seq_chunk_adder.
// Covers the 16/4 build, plus WIDTH=4 builds with CHUNK=1, 2 and 4 that are
// checked exhaustively against a reference model.
module tb_seq_chunk_adder;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Main 16-bit, 4-bit-chunk instance.
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;
  logic [1:0]   state_dbg;

  // Shared stimulus for the three 4-bit instances.
  // Index 0: CHUNK=1. Index 1: CHUNK=2. Index 2: CHUNK=4.
  logic       x_start = 1'b0;
  logic       x_sub = 1'b0;
  logic [3:0] x_a = '0;
  logic [3:0] x_b = '0;
  logic       x_cin = 1'b0;
  logic       x_busy [3];
  logic       x_done [3];
  logic       x_cout [3];
  logic       x_ovf  [3];
  logic [3:0] x_sum  [3];
  logic [1:0] x_state [3];

  int n_vec = 0;
  int n_err = 0;

  seq_chunk_adder #(.WIDTH(W), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .state_dbg(state_dbg)
  );

  seq_chunk_adder #(.WIDTH(4), .CHUNK(1)) dut_c1 (
    .clk(clk), .rst(rst), .start(x_start), .sub(x_sub), .a(x_a), .b(x_b),
    .cin(x_cin), .busy(x_busy[0]), .done(x_done[0]), .sum(x_sum[0]),
    .cout(x_cout[0]), .ovf(x_ovf[0]), .state_dbg(x_state[0])
  );

  seq_chunk_adder #(.WIDTH(4), .CHUNK(2)) dut_c2 (
    .clk(clk), .rst(rst), .start(x_start), .sub(x_sub), .a(x_a), .b(x_b),
    .cin(x_cin), .busy(x_busy[1]), .done(x_done[1]), .sum(x_sum[1]),
    .cout(x_cout[1]), .ovf(x_ovf[1]), .state_dbg(x_state[1])
  );

  seq_chunk_adder #(.WIDTH(4), .CHUNK(4)) dut_c4 (
    .clk(clk), .rst(rst), .start(x_start), .sub(x_sub), .a(x_a), .b(x_b),
    .cin(x_cin), .busy(x_busy[2]), .done(x_done[2]), .sum(x_sum[2]),
    .cout(x_cout[2]), .ovf(x_ovf[2]), .state_dbg(x_state[2])
  );

  // Clock and reset.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation on the main instance. The operands are scrambled right
  // after acceptance, so the result must come from the latched values.
  task automatic run_op(input string tag, input logic s, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic ci,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    int cyc;
    start = 1'b1; sub = s; a = av; b = bv; cin = ci;
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = ~s; cin = ~ci;
    chk({tag, "_busy_acc"}, 32'(busy), 32'd1);
    chk({tag, "_flags_clr"}, {30'd0, cout, ovf}, 32'd0);
    cyc = 1;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
      if (!done) chk({tag, "_busy_run"}, 32'(busy), 32'd1);
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd5);
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout_ovf"}, {30'd0, cout, ovf}, {30'd0, ec, eo});
    tick();
    chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    chk({tag, "_sum_hold"}, 32'(sum), 32'(es));
  endtask

  // One case, applied to all three 4-bit instances at once.
  task automatic exh_case(input logic s, input logic [3:0] av, input logic [3:0] bv,
                          input logic ci);
    logic [4:0] full;
    logic [3:0] es;
    logic       ec, eo;
    int         lat [3];
    logic [5:0] got [3];
    int         exp_lat [3];
    string      tag;
    exp_lat[0] = 5; exp_lat[1] = 3; exp_lat[2] = 2;
    if (!s) begin
      full = {1'b0, av} + {1'b0, bv} + {4'd0, ci};
      es = full[3:0];
      ec = full[4];
      eo = (av[3] == bv[3]) && (es[3] != av[3]);
    end else begin
      full = {1'b0, av} - {1'b0, bv} - {4'd0, ci};
      es = full[3:0];
      ec = (int'(av) < int'(bv) + int'(ci));
      eo = (av[3] != bv[3]) && (es[3] != av[3]);
    end
    x_start = 1'b1; x_sub = s; x_a = av; x_b = bv; x_cin = ci;
    for (int j = 0; j < 3; j++) begin
      lat[j] = 0;
      got[j] = '0;
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) x_start = 1'b0;
      for (int j = 0; j < 3; j++) begin
        if (x_done[j] && lat[j] == 0) begin
          lat[j] = k;
          got[j] = {x_sum[j], x_cout[j], x_ovf[j]};
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      tag = $sformatf("exh_i%0d_s%0d_a%0h_b%0h_c%0d", j, s, av, bv, ci);
      chk({tag, "_res"}, 32'(got[j]), 32'({es, ec, eo}));
      chk({tag, "_lat"}, 32'(lat[j]), 32'(exp_lat[j]));
      chk({tag, "_idle"}, 32'(x_state[j]), 32'd0);
    end
  endtask

  initial begin
    int cyc;

    // Reset state.
    tick();
    tick();
    chk("rst_outputs", {28'd0, busy, done, cout, ovf}, 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    tick();

    // Arithmetic vectors, hand-computed.
    run_op("add_wrap",  1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",   1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("add_cin",   1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    run_op("add_negov", 1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("sub_borrow",1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b1, 1'b0);
    run_op("sub_ovf",   1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    run_op("sub_bin",   1'b1, 16'h0003, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b0);
    run_op("sub_all1",  1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    // start held high: accepted only from idle, one operation per 6 cycles.
    start = 1'b1; sub = 1'b0; a = 16'h0102; b = 16'h0304; cin = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      chk($sformatf("hold_done_k%0d", k), 32'(done), 32'((k % 6) == 5));
      if (done) chk("hold_sum", 32'(sum), 32'h0406);
    end
    start = 1'b0;
    tick();

    // start pulsed during the run, and again in the done cycle: both ignored.
    start = 1'b1; a = 16'h0100; b = 16'h0023; cin = 1'b0; sub = 1'b0;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1;
    tick();
    start = 1'b0;
    cyc = 3;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("pulse_latency", 32'(cyc), 32'd5);
    chk("pulse_sum", 32'(sum), 32'h0123);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("pulse_done_ign", {30'd0, busy, done}, 32'd0);
    tick();
    chk("pulse_stay_idle", 32'(busy), 32'd0);
    chk("pulse_sum_hold", 32'(sum), 32'h0123);

    // Reset during the second run cycle abandons the operation.
    run_op("pre_rst", 1'b0, 16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_flags", {28'd0, busy, done, cout, ovf}, 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("midrst_no_done", {30'd0, busy, done}, 32'd0);
    end
    run_op("post_rst", 1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Exhaustive check of the WIDTH=4 builds.
    for (int s = 0; s < 2; s++)
      for (int ai = 0; ai < 16; ai++)
        for (int bi = 0; bi < 16; bi++)
          for (int ci = 0; ci < 2; ci++)
            exh_case(1'(s), 4'(ai), 4'(bi), 1'(ci));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
Parametrised multi-cycle ripple adder/subtractor, the successor to the combinational four-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, carrying between chunks in a register, so wide operands do not need one long combinational carry chain.
- Handshake is START/BUSY/DONE.
- Flags: unsigned carry/borrow and signed overflow.
- Used in datapaths that trade latency for short critical paths.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be ≥ 1 and an integer multiple of CHUNK.
- CHUNK, 4, bits processed per RUN cycle. 1 ≤ CHUNK ≤ WIDTH.
- NCHUNK (local), WIDTH/CHUNK, number of RUN cycles.

Ports:
- CLK  input  1  single clock; all logic on rising edge
- RST  input  1  synchronous, active-high reset
- START  input  1  request; sampled only in IDLE
- SUB  input  1  mode, sampled with START: 0 gives A+B+CIN, 1 gives A−B−CIN
- A  input  WIDTH  operand A, sampled with START
- B  input  WIDTH  operand B, sampled with START
- CIN  input  1  carry-in (add) or borrow-in (sub), sampled with START
- BUSY  output  1  high in RUN and DONE_ST
- DONE  output  1  one-cycle pulse; result valid
- SUM  output  WIDTH  result, registered
- COUT  output  1  add: carry-out. Sub: borrow-out (1 when A < B+CIN, unsigned)
- OVF  output  1  signed two's-complement overflow

Behaviour:
- Reset (RST=1 at a rising edge, any state, including mid-operation):
  - state goes to IDLE.
  - BUSY, DONE, SUM, COUT, OVF all become 0.
  - Internal operand, carry and chunk-index registers are cleared.
  - Any operation in progress is abandoned and no DONE is produced.
- States: IDLE, RUN, DONE_ST.
- IDLE:
  - If START=1 at edge t0: latch A into opA.
  - Latch B (SUB=0) or ~B (SUB=1) into opB.
  - Carry register: c = CIN (add) or c = ~CIN (sub).
  - idx = 0; go to RUN.
  - If START=0: stay in IDLE.
- RUN:
  - Each edge computes {c', s} = opA[idx chunk] + opB[idx chunk] + c, where the idx chunk is bits idx·CHUNK .. idx·CHUNK+CHUNK−1.
  - s is written into the matching SUM bits and c is updated to c'.
  - On the last chunk (idx = NCHUNK−1), the carry into bit WIDTH−1 is also captured as cm, and the FSM goes to DONE_ST.
  - Otherwise idx increments.
- DONE_ST:
  - DONE = 1 for exactly one cycle.
  - COUT = c (add) or ~c (sub).
  - OVF = cm XOR c (raw carries, both modes).
  - Next edge returns to IDLE.
- Latency: START sampled at edge t0; the final chunk is written at edge t(NCHUNK); DONE is high in the cycle after that edge. With CHUNK=WIDTH, DONE follows one cycle after acceptance.
- Back-to-back throughput: one operation per NCHUNK+2 cycles. START is accepted only in IDLE; START high while BUSY=1 (including the DONE cycle) is ignored, not queued.
- Input stability: A, B, SUB and CIN changing after t0 have no effect.
- Output hold:
  - SUM, COUT and OVF hold the last result until the next accepted START.
  - From acceptance onward, SUM is updated chunk by chunk and is valid only when DONE=1 or afterwards in IDLE.
  - COUT and OVF are cleared at acceptance.
- Arithmetic is modulo 2^WIDTH; no saturation.

Test Plan:
- Add wrap, WIDTH=16 CHUNK=4: A=0xFFFF, B=0x0001, CIN=0, SUB=0 -> DONE exactly 5 cycles after START edge (4 RUN + DONE cycle), SUM=0x0000, COUT=1, OVF=0; BUSY high for 5 cycles, then IDLE.
- Signed overflow add: A=0x7FFF, B=0x0001, CIN=0 -> SUM=0x8000, COUT=0, OVF=1. Then A=0x1234, B=0x4321, CIN=1 -> SUM=0x5556, COUT=0, OVF=0.
- Subtract: SUB=1, A=0x0005, B=0x0007, CIN=0 -> SUM=0xFFFE, COUT(borrow)=1, OVF=0. SUB=1, A=0x8000, B=0x0001, CIN=0 -> SUM=0x7FFF, COUT=0, OVF=1. SUB=1, A=0x0003, B=0x0001, CIN=1 -> SUM=0x0001, COUT=0.
- Handshake:
  - START held high continuously -> operations start only from IDLE, one per 6 cycles.
  - Operands changed on the cycle after acceptance -> result reflects the latched values.
  - START pulsed during RUN -> ignored.
- Reset mid-op: assert RST at the 2nd RUN cycle -> next cycle BUSY=0, DONE=0, SUM=0, COUT=0, OVF=0; no later DONE. A fresh START afterwards completes normally.
- Exhaustive, WIDTH=4 with CHUNK=1, 2 and 4: all A, B, CIN, SUB (1024 cases) vs behavioural model of SUM/COUT/OVF -> zero mismatches; DONE latency = NCHUNK+1 cycles in every case.
